// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - circular-buffer FIFO controller around one dpram (port A write, port B read)
module dpram_fifo_ctrl #(
   parameter int DATA     = 16,
   parameter int ADDR     = 5,
   parameter int AF_LEVEL = 28,
   parameter int AE_LEVEL = 4
) (
   input  logic            clK,
   input  logic            rst,
   input  logic            flush,
   input  logic            push_valid,
   output logic            push_ready,
   input  logic [DATA-1:0] push_data,
   output logic            pop_valid,
   input  logic            pop_ready,
   output logic [DATA-1:0] pop_data,
   output logic [ADDR:0]   count,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic            almost_empty,
   output logic            overflow,
   output logic            underflow,
   output logic            ram_a_WR,
   output logic [ADDR-1:0] ram_a_ADDR,
   output logic [DATA-1:0] ram_a_data_IN,
   output logic            ram_b_WR,
   output logic [ADDR-1:0] ram_b_ADDR,
   input  logic [DATA-1:0] ram_b_data_OUT
);

   localparam logic [ADDR:0] ONE  = (ADDR+1)'(1);
   localparam logic [ADDR:0] AF_L = (ADDR+1)'(AF_LEVEL);
   localparam logic [ADDR:0] AE_L = (ADDR+1)'(AE_LEVEL);

   logic [ADDR:0] wr_ptr;
   logic [ADDR:0] rd_ptr;
   logic [ADDR:0] count_q;
   logic          overflow_q;
   logic          underflow_q;
   logic          push_fire;
   logic          pop_fire;

   // Extra wrap bit distinguishes full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR] != rd_ptr[ADDR]) && (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);

   assign push_ready   = ~full;
   assign pop_valid    = ~empty;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_L);
   assign almost_empty = (count_q <= AE_L);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign push_fire = push_valid & ~full;
   assign pop_fire  = pop_ready & ~empty;

   assign ram_a_WR      = push_fire & ~flush & ~rst;
   assign ram_a_ADDR    = wr_ptr[ADDR-1:0];
   assign ram_a_data_IN = push_data;
   assign ram_b_WR      = 1'b0;
   assign ram_b_ADDR    = rd_ptr[ADDR-1:0];
   assign pop_data      = ram_b_data_OUT;

   always_ff @(posedge clK) begin
      if (rst || flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_fire)
            wr_ptr <= wr_ptr + ONE;
         if (pop_fire)
            rd_ptr <= rd_ptr + ONE;
         case ({push_fire, pop_fire})
            2'b10:   count_q <= count_q + ONE;
            2'b01:   count_q <= count_q - ONE;
            default: count_q <= count_q;
         endcase
         if (push_valid && full)
            overflow_q <= 1'b1;
         if (pop_ready && empty)
            underflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - self-checking bench for dpram_fifo_ctrl with a behavioural dpram
module tb_dpram_fifo_ctrl;

   logic        clK = 1'b0;
   logic        rst, flush, push_valid, pop_ready;
   logic [15:0] push_data;
   logic        push_ready, pop_valid, full, empty, almost_full, almost_empty;
   logic        overflow, underflow, ram_a_WR, ram_b_WR;
   logic [15:0] pop_data, ram_a_data_IN, ram_b_data_OUT;
   logic [5:0]  count;
   logic [4:0]  ram_a_ADDR, ram_b_ADDR;

   logic [15:0] mem [32];

   int checks   = 0;
   int failures = 0;

   logic [15:0] sb[$];
   int          m_count;
   logic        m_ovf, m_unf;

   typedef struct {
      logic        r, fl, pv;
      logic [15:0] pd;
      logic        pr;
      logic [5:0]  e_count;
      logic        e_pv;
      logic        e_chkd;
      logic [15:0] e_data;
      logic        e_unf;
   } vec_t;

   vec_t tbl [10];

   always #5 clK = ~clK;

   always @(posedge clK)
      if (ram_a_WR)
         mem[ram_a_ADDR] <= ram_a_data_IN;
   assign ram_b_data_OUT = mem[ram_b_ADDR];

   dpram_fifo_ctrl #(.DATA(16), .ADDR(5), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
      .clK(clK), .rst(rst), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow),
      .ram_a_WR(ram_a_WR), .ram_a_ADDR(ram_a_ADDR), .ram_a_data_IN(ram_a_data_IN),
      .ram_b_WR(ram_b_WR), .ram_b_ADDR(ram_b_ADDR), .ram_b_data_OUT(ram_b_data_OUT)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle: compare against the model mid-cycle, then advance the model at the edge.
   task automatic step(input logic r, input logic fl, input logic pv, input logic [15:0] pd, input logic pr);
      logic pf, qf;
      rst = r; flush = fl; push_valid = pv; push_data = pd; pop_ready = pr;
      #4;
      chk("count", 32'(count), 32'(m_count));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("full", 32'(full), 32'(m_count == 32));
      chk("push_ready", 32'(push_ready), 32'(m_count != 32));
      chk("pop_valid", 32'(pop_valid), 32'(m_count != 0));
      chk("almost_full", 32'(almost_full), 32'(m_count >= 28));
      chk("almost_empty", 32'(almost_empty), 32'(m_count <= 4));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("ram_b_WR", 32'(ram_b_WR), 32'(0));
      pf = pv && (m_count != 32) && !fl && !r;
      qf = pr && (m_count != 0) && !fl && !r;
      chk("ram_a_WR", 32'(ram_a_WR), 32'(pf));
      if (pf) chk("ram_a_data_IN", 32'(ram_a_data_IN), 32'(pd));
      if (m_count != 0) chk("pop_data", 32'(pop_data), 32'(sb[0]));
      if (r || fl) begin
         sb.delete();
         m_count = 0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else begin
         if (pv && m_count == 32) m_ovf = 1'b1;
         if (pr && m_count == 0)  m_unf = 1'b1;
         if (qf) void'(sb.pop_front());
         if (pf) sb.push_back(pd);
         m_count = m_count + (pf ? 1 : 0) - (qf ? 1 : 0);
      end
      @(posedge clK);
      #1;
   endtask

   initial begin
      int wraps;
      logic [4:0] prev_b, a_hold;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 6'd1, 1'b1, 1'b1, 16'h0001, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 6'd2, 1'b1, 1'b1, 16'h0001, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 6'd3, 1'b1, 1'b1, 16'h0001, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd2, 1'b1, 1'b1, 16'h0002, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd1, 1'b1, 1'b1, 16'h0003, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd0, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd0, 1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 6'd1, 1'b1, 1'b1, 16'h0055, 1'b0};

      rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
      @(posedge clK);
      #1;
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].fl, tbl[i].pv, tbl[i].pd, tbl[i].pr);
         #3;
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
         chk($sformatf("tbl%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].e_pv));
         chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].e_unf));
         if (tbl[i].e_chkd)
            chk($sformatf("tbl%0d_pop_data", i), 32'(pop_data), 32'(tbl[i].e_data));
         #1;
      end

      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      a_hold = ram_b_ADDR;
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("unf_rd_ptr_hold", 32'(ram_b_ADDR), 32'(a_hold));
      chk("unf_set", 32'(underflow), 32'(1));
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("flush_unf_clr", 32'(underflow), 32'(0));
      chk("flush_empty", 32'(empty), 32'(1));

      for (int i = 0; i < 32; i++)
         step(1'b0, 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_push_ready", 32'(push_ready), 32'(0));
      step(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0);
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_count", 32'(count), 32'(32));
      chk("ovf_head", 32'(pop_data), 32'(16'h0100));

      step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
      chk("full_pushpop_count", 32'(count), 32'(31));
      for (int i = 0; i < 21; i++)
         step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("drain_to10", 32'(count), 32'(10));
      step(1'b0, 1'b0, 1'b1, 16'h0C0C, 1'b1);
      chk("mid_pushpop_count", 32'(count), 32'(10));
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

      wraps = 0;
      step(1'b0, 1'b0, 1'b1, 16'h2000, 1'b0);
      prev_b = ram_b_ADDR;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b0, 1'b1, 16'(16'h2001 + i), 1'b1);
         if (ram_b_ADDR == 5'd0 && prev_b == 5'd31) wraps++;
         prev_b = ram_b_ADDR;
      end
      chk("wrap_count", 32'(count), 32'(1));
      chk("wrap_seen", 32'(wraps >= 3), 32'(1));
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("wrap_drained", 32'(empty), 32'(1));

      for (int i = 0; i < 17; i++)
         step(1'b0, 1'b0, 1'b1, 16'(16'h3000 + i), 1'b0);
      chk("pre_rst_count", 32'(count), 32'(17));
      step(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0);
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
